// File: rtl/cpu_token_dispatcher.sv
// Bus-token dispatcher: enumerates CPU bridges at reset, then circulates a single ownership
// token round-robin among requesting CPUs, with a watchdog that drops unresponsive CPUs.
module cpu_token_dispatcher #(
    parameter int unsigned NCPU    = 4,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [NCPU-1:0]   cpu_rst_b,
    input  logic              cpu_rst_e,
    output logic [DATA_W-1:0] cpu_index,
    output logic              next_cpu_q,
    input  logic              next_cpu_e,
    input  logic [NCPU-1:0]   dispatcher_q,
    input  logic              bus_busy,
    output logic [IDX_W-1:0]  owner,
    output logic              owner_valid,
    output logic [NCPU-1:0]   present,
    output logic              enum_done,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        StEnumDrive,
        StEnumWait,
        StArb,
        StGrant,
        StHold
    } state_e;

    localparam logic [7:0]       WdLimit = 8'(TIMEOUT);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NCPU - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  e_q, e_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [7:0]        wd_q, wd_d;
    logic [NCPU-1:0]   cpu_rst_b_q, cpu_rst_b_d;
    logic [DATA_W-1:0] cpu_index_q, cpu_index_d;
    logic              offer_q, offer_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              owner_valid_q, owner_valid_d;
    logic [NCPU-1:0]   present_q, present_d;
    logic              enum_done_q, enum_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic [NCPU-1:0]   eligible;
    logic [NCPU-1:0]   e_bit;
    logic [NCPU-1:0]   owner_bit;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    int unsigned       cand;
    logic              release_tok;

    assign e_bit     = NCPU'(1) << e_q;
    assign owner_bit = NCPU'(1) << owner_q;

    // Round-robin search upward from ptr; ptr is always < NCPU so one subtraction wraps it.
    always_comb begin
        eligible  = dispatcher_q & present_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NCPU; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NCPU) begin
                cand = cand - NCPU;
            end
            if (!win_found && ((eligible & (NCPU'(1) << cand)) != '0)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        e_d           = e_q;
        ptr_d         = ptr_q;
        wd_d          = wd_q;
        cpu_rst_b_d   = '0;
        cpu_index_d   = cpu_index_q;
        offer_d       = offer_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        present_d     = present_q;
        enum_done_d   = enum_done_q;
        timeout_err_d = 1'b0;
        release_tok   = 1'b0;

        unique case (state_q)
            StEnumDrive: begin
                cpu_rst_b_d = e_bit;
                cpu_index_d = DATA_W'(e_q);
                wd_d        = '0;
                state_d     = StEnumWait;
            end
            StEnumWait: begin
                if (cpu_rst_e || (wd_q == WdLimit)) begin
                    // An acknowledge arriving on the expiry cycle still counts.
                    if (cpu_rst_e) begin
                        present_d = present_q | e_bit;
                    end else begin
                        present_d     = present_q & ~e_bit;
                        timeout_err_d = 1'b1;
                    end
                    if (e_q == LastIdx) begin
                        enum_done_d = 1'b1;
                        state_d     = StArb;
                    end else begin
                        e_d     = e_q + 1'b1;
                        state_d = StEnumDrive;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            StArb: begin
                if (!bus_busy && win_found) begin
                    owner_d       = win_idx;
                    owner_valid_d = 1'b1;
                    cpu_index_d   = DATA_W'(win_idx);
                    offer_d       = 1'b1;
                    wd_d          = '0;
                    state_d       = StGrant;
                end
            end
            StGrant: begin
                if (next_cpu_e) begin
                    offer_d = 1'b0;
                    wd_d    = '0;
                    state_d = StHold;
                end else if (wd_q == WdLimit) begin
                    timeout_err_d = 1'b1;
                    present_d     = present_q & ~owner_bit;
                    release_tok   = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            StHold: begin
                if (!next_cpu_e) begin
                    release_tok = 1'b1;
                end else if (wd_q == WdLimit) begin
                    timeout_err_d = 1'b1;
                    present_d     = present_q & ~owner_bit;
                    release_tok   = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: state_d = StEnumDrive;
        endcase

        if (release_tok) begin
            offer_d       = 1'b0;
            owner_valid_d = 1'b0;
            cpu_index_d   = '0;
            ptr_d         = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
            state_d       = StArb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StEnumDrive;
            e_q           <= '0;
            ptr_q         <= '0;
            wd_q          <= '0;
            cpu_rst_b_q   <= '0;
            cpu_index_q   <= '0;
            offer_q       <= 1'b0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            present_q     <= '0;
            enum_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            e_q           <= e_d;
            ptr_q         <= ptr_d;
            wd_q          <= wd_d;
            cpu_rst_b_q   <= cpu_rst_b_d;
            cpu_index_q   <= cpu_index_d;
            offer_q       <= offer_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            present_q     <= present_d;
            enum_done_q   <= enum_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cpu_rst_b   = cpu_rst_b_q;
    assign cpu_index   = cpu_index_q;
    assign next_cpu_q  = offer_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign present     = present_q;
    assign enum_done   = enum_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cpu_token_dispatcher.sv
// Bench for cpu_token_dispatcher: emulated CPU bridges plus a transaction-level model of
// enumeration timing, round-robin winner selection and watchdog expiry.
module tb_cpu_token_dispatcher;

    localparam int unsigned NCPU    = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCPU-1:0]   cpu_rst_b;
    logic              cpu_rst_e;
    logic [DATA_W-1:0] cpu_index;
    logic              next_cpu_q;
    logic              next_cpu_e;
    logic [NCPU-1:0]   dispatcher_q;
    logic              bus_busy;
    logic [IDX_W-1:0]  owner;
    logic              owner_valid;
    logic [NCPU-1:0]   present;
    logic              enum_done;
    logic              timeout_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    int unsigned     ptr_m;
    logic [NCPU-1:0] present_m;

    cpu_token_dispatcher #(
        .NCPU   (NCPU),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_rst_b   (cpu_rst_b),
        .cpu_rst_e   (cpu_rst_e),
        .cpu_index   (cpu_index),
        .next_cpu_q  (next_cpu_q),
        .next_cpu_e  (next_cpu_e),
        .dispatcher_q(dispatcher_q),
        .bus_busy    (bus_busy),
        .owner       (owner),
        .owner_valid (owner_valid),
        .present     (present),
        .enum_done   (enum_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First requesting, present CPU at or after p, going round the ring.
    function automatic int unsigned pick(input logic [NCPU-1:0] elig, input int unsigned p);
        for (int unsigned k = 0; k < NCPU; k++) begin
            if (elig[(p + k) % NCPU]) return (p + k) % NCPU;
        end
        return NCPU;
    endfunction

    // Starts at the sample point right after rst_n rises. Alive CPUs ack `delay` cycles after
    // seeing their pulse; a slot costs 1+delay cycles when alive, 1+TIMEOUT+1 when dead.
    task automatic run_enum(input logic [NCPU-1:0] alive, input int unsigned delay,
                            input string tag);
        int unsigned slot = 0;
        int unsigned edges = 0;
        int unsigned exp_edges = 0;
        int unsigned tmo = 0;
        int unsigned dead = 0;
        int unsigned ack_at = 0;
        bit          ack_pending = 1'b0;
        logic [31:0] one = 32'd1;
        for (int unsigned i = 0; i < NCPU; i++) begin
            exp_edges += alive[i] ? (1 + delay) : (2 + TIMEOUT);
            if (!alive[i]) dead++;
        end
        while (!enum_done && edges < exp_edges + 50) begin
            cpu_rst_e = 1'b0;
            if (ack_pending && edges == ack_at) begin
                cpu_rst_e   = 1'b1;
                ack_pending = 1'b0;
            end
            step();
            edges++;
            if (timeout_err) tmo++;
            if (cpu_rst_b != '0) begin
                check({tag, "_rst_b"}, 32'(cpu_rst_b), one << slot);
                check({tag, "_index"}, cpu_index, slot);
                if (slot < NCPU && alive[slot]) begin
                    ack_pending = 1'b1;
                    ack_at      = edges + delay - 1;
                end
                slot++;
            end
        end
        cpu_rst_e = 1'b0;
        check({tag, "_done"}, 32'(enum_done), 1);
        check({tag, "_cycles"}, edges, exp_edges);
        check({tag, "_pulses"}, slot, NCPU);
        check({tag, "_present"}, 32'(present), 32'(alive));
        check({tag, "_timeouts"}, tmo, dead);
        check({tag, "_nooffer"}, 32'(owner_valid), 0);
        present_m = alive;
        ptr_m     = 0;
    endtask

    // Entered with the DUT idle in arbitration.
    task automatic grant_txn(input logic [NCPU-1:0] req, input int unsigned busy,
                             input int unsigned hold, input string tag);
        int unsigned w;
        int unsigned stall_offers = 0;
        w            = pick(req & present_m, ptr_m);
        dispatcher_q = req;
        bus_busy     = (busy != 0);
        for (int unsigned i = 0; i < busy; i++) begin
            step();
            if (next_cpu_q) stall_offers++;
        end
        if (busy != 0) check({tag, "_stall"}, stall_offers, 0);
        bus_busy = 1'b0;
        step();
        if (w == NCPU) begin
            repeat (3) step();
            check({tag, "_noofr"}, {31'd0, next_cpu_q | owner_valid}, 0);
            return;
        end
        check({tag, "_offer"}, 32'(next_cpu_q), 1);
        check({tag, "_owner"}, 32'(owner), w);
        check({tag, "_index"}, cpu_index, w);
        check({tag, "_valid"}, 32'(owner_valid), 1);
        // Withdrawing the request must not withdraw the offer.
        dispatcher_q = '0;
        step();
        check({tag, "_held"}, 32'(next_cpu_q), 1);
        next_cpu_e = 1'b1;
        step();
        check({tag, "_ackoff"}, {30'd0, next_cpu_q, owner_valid}, 32'b01);
        repeat (hold - 1) step();
        next_cpu_e = 1'b0;
        step();
        check({tag, "_rel"}, {31'd0, owner_valid}, 0);
        check({tag, "_relidx"}, cpu_index, 0);
        ptr_m = (w + 1) % NCPU;
    endtask

    initial begin
        int unsigned n;
        logic [NCPU-1:0] r;
        rst_n        = 1'b1;
        cpu_rst_e    = 1'b0;
        next_cpu_e   = 1'b0;
        dispatcher_q = '0;
        bus_busy     = 1'b0;
        present_m    = '0;
        ptr_m        = 0;
        #3 rst_n = 1'b0;
        #1;
        check("reset_outs", {cpu_rst_b, present, 1'b0, next_cpu_q, owner_valid, enum_done,
                             timeout_err}, 0);
        check("reset_idx", cpu_index, 0);
        repeat (3) step();
        rst_n = 1'b1;
        run_enum(4'b1111, 2, "enum1");

        for (int unsigned i = 0; i < 5; i++) grant_txn(4'b1111, 0, 3, "rr");

        grant_txn(4'b0100, 10, 3, "stall");
        grant_txn(4'b0001, 0, 2, "wrap");

        for (int unsigned i = 0; i < 20; i++) begin
            r = NCPU'($urandom);
            grant_txn(r, $urandom_range(0, 3), $urandom_range(1, 6), "rand1");
        end

        // CPU1 holds the token past the watchdog limit.
        dispatcher_q = 4'b0010;
        step();
        check("wd_owner", {27'd0, next_cpu_q, owner}, {27'd0, 1'b1, 4'd1});
        next_cpu_e   = 1'b1;
        dispatcher_q = '0;
        step();
        n = 0;
        while (!timeout_err && n < 300) begin
            step();
            n++;
        end
        check("wd_cycles", n, TIMEOUT + 1);
        check("wd_present", 32'(present), 32'(present_m & 4'b1101));
        check("wd_rel", {30'd0, owner_valid, next_cpu_q}, 0);
        next_cpu_e = 1'b0;
        step();
        check("wd_pulse", 32'(timeout_err), 0);
        present_m[1] = 1'b0;
        ptr_m        = 2;
        grant_txn(4'b1111, 0, 2, "wd_next");
        grant_txn(4'b0010, 0, 2, "wd_dead");

        // Asynchronous reset while a CPU holds the bus.
        dispatcher_q = 4'b0001;
        step();
        next_cpu_e = 1'b1;
        repeat (2) step();
        check("ar_pre", {31'd0, owner_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("ar_async", {23'd0, present, next_cpu_q, owner_valid, enum_done}, 0);
        next_cpu_e   = 1'b0;
        dispatcher_q = '0;
        repeat (2) step();
        check("ar_quiet", 32'(cpu_rst_b), 0);
        rst_n = 1'b1;
        run_enum(4'b1011, 2, "enum2");

        grant_txn(4'b0100, 0, 2, "dead2");
        for (int unsigned i = 0; i < 15; i++) begin
            r = NCPU'($urandom) | 4'b0100;
            grant_txn(r, $urandom_range(0, 2), $urandom_range(1, 4), "rand2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
